// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS core: hazard detection, per-register
// control codes, mult/div occupancy countdown and a saturating stall counter.
module hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_wait,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             id_md_read,
    output logic [1:0]       sig_pc,
    output logic [1:0]       sig_ifid,
    output logic [1:0]       sig_idex,
    output logic [1:0]       sig_exmem,
    output logic [1:0]       sig_memwb,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] CTL_FLUSH = 2'd0;
    localparam logic [1:0] CTL_LOAD  = 2'd1;
    localparam logic [1:0] CTL_HOLD  = 2'd2;

    localparam int              MD_W    = 8;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_CYCLES);
    localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        SEL_WAIT,
        SEL_BRANCH,
        SEL_STALL,
        SEL_JUMP,
        SEL_RUN
    } sel_t;

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_done_q, md_done_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic mdh;
    logic stall;
    logic md_accept;
    sel_t sel;

    logic [1:0] pc_c, ifid_c, idex_c, exmem_c, memwb_c;

    assign md_busy = (md_cnt_q != '0);

    always_comb begin
        lu    = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        mdh   = md_busy && (id_md_start || id_md_read);
        stall = lu || mdh;
    end

    always_comb begin
        sel = SEL_RUN;
        if (mem_wait) begin
            sel = SEL_WAIT;
        end else if (ex_branch_taken) begin
            sel = SEL_BRANCH;
        end else if (stall) begin
            sel = SEL_STALL;
        end else if (id_jump) begin
            sel = SEL_JUMP;
        end
    end

    always_comb begin
        pc_c    = CTL_LOAD;
        ifid_c  = CTL_LOAD;
        idex_c  = CTL_LOAD;
        exmem_c = CTL_LOAD;
        memwb_c = CTL_LOAD;
        unique case (sel)
            SEL_WAIT: begin
                pc_c    = CTL_HOLD;
                ifid_c  = CTL_HOLD;
                idex_c  = CTL_HOLD;
                exmem_c = CTL_HOLD;
                memwb_c = CTL_HOLD;
            end
            SEL_BRANCH: begin
                ifid_c = CTL_FLUSH;
                idex_c = CTL_FLUSH;
            end
            SEL_STALL: begin
                pc_c   = CTL_HOLD;
                ifid_c = CTL_HOLD;
                idex_c = CTL_FLUSH;
            end
            SEL_JUMP: begin
                ifid_c = CTL_FLUSH;
            end
            default: begin
            end
        endcase
    end

    // Every control code reads as flush while reset is held, independent of the clock.
    always_comb begin
        sig_pc    = rst ? pc_c    : CTL_FLUSH;
        sig_ifid  = rst ? ifid_c  : CTL_FLUSH;
        sig_idex  = rst ? idex_c  : CTL_FLUSH;
        sig_exmem = rst ? exmem_c : CTL_FLUSH;
        sig_memwb = rst ? memwb_c : CTL_FLUSH;
    end

    // Busy already forces a stall on any mult/div, so acceptance only happens when idle.
    assign md_accept = id_md_start && !mem_wait && !ex_branch_taken && !stall;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_accept) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_ONE;
        end
    end

    always_comb begin
        md_done_d = (md_cnt_q == MD_ONE);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((sel == SEL_STALL) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt_q    <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_done   = md_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes reference expectations,
// a monitor on the rising edge pops and compares them against the DUT.
module tb_hazard_ctrl;

    localparam int MD  = 4;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          mem_wait, ex_branch_taken, id_jump, ex_memread;
    logic [4:0]    ex_rt, id_rs, id_rt;
    logic          id_uses_rt, id_md_start, id_md_read;
    logic [1:0]    sig_pc, sig_ifid, sig_idex, sig_exmem, sig_memwb;
    logic          md_busy, md_done;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_wait(mem_wait), .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .id_md_read(id_md_read),
        .sig_pc(sig_pc), .sig_ifid(sig_ifid), .sig_idex(sig_idex),
        .sig_exmem(sig_exmem), .sig_memwb(sig_memwb),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    typedef struct {
        int         cyc;
        logic [9:0] sigs;
        logic       busy;
        logic       done;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc_no = 0;

    // reference state: cycles left on the mult/div unit, pending done, stall count
    int   m_rem  = 0;
    bit   m_done = 0;
    int   m_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
    endtask

    always @(posedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("sigs",      e.cyc, int'({sig_pc, sig_ifid, sig_idex, sig_exmem, sig_memwb}), int'(e.sigs));
            check("md_busy",   e.cyc, int'(md_busy), int'(e.busy));
            check("md_done",   e.cyc, int'(md_done), int'(e.done));
            check("stall_cnt", e.cyc, int'(stall_cnt), e.cnt);
        end
    end

    task automatic step(input bit r, input bit mw, input bit br, input bit jp,
                        input bit mr, input int ert, input int rs, input int rt,
                        input bit urt, input bit mds, input bit mdr);
        exp_t e;
        bit lu, stall, accept, case3;
        @(negedge clk);
        #1;
        rst = r; mem_wait = mw; ex_branch_taken = br; id_jump = jp;
        ex_memread = mr; ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rt = urt; id_md_start = mds; id_md_read = mdr;
        if (!r) begin
            m_rem = 0; m_done = 0; m_cnt = 0;
        end
        lu    = mr && (ert != 0) && (ert == rs || (urt && ert == rt));
        stall = lu || ((m_rem > 0) && (mds || mdr));
        case3 = 0;
        if (!r)         e.sigs = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        else if (mw)    e.sigs = {2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        else if (br)    e.sigs = {2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        else if (stall) begin e.sigs = {2'd2, 2'd2, 2'd0, 2'd1, 2'd1}; case3 = 1; end
        else if (jp)    e.sigs = {2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
        else            e.sigs = {2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        e.cyc  = cyc_no;
        e.busy = (m_rem > 0);
        e.done = m_done;
        e.cnt  = m_cnt;
        q.push_back(e);
        cyc_no++;
        if (r) begin
            accept = mds && !mw && !br && !stall;
            m_done = (m_rem == 1);
            if (case3 && m_cnt < MAXC) m_cnt++;
            if (accept) m_rem = MD;
            else if (m_rem > 0) m_rem--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; mem_wait = 0; ex_branch_taken = 0; id_jump = 0; ex_memread = 0;
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_md_start = 0; id_md_read = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 5, 5, 0, 0, 0, 0);
        idle(1);
        // load-use, then the same with r0 as destination
        step(1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 7, 1, 7, 1, 0, 0);
        step(1, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0);
        // branch overrides load-use and jump
        step(1, 0, 1, 1, 1, 5, 5, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // mult/div start, then mfhi held in ID while busy
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // back-to-back mult/div
        for (int i = 0; i < 2 * (MD + 1) + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(MD + 2);
        // mem_wait during countdown, and a squashed start under branch
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 3, 3, 0, 0, 0, 1);
        idle(3);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // saturation
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 9, 9, 0, 0, 0, 0);
        idle(1);
        // reset with counter at 2
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(MD + 2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", cyc_no, q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
